// File: rtl/rx_buffer_if.sv
// Handshake bundle for rx_buffer: header/timestamp ingress, gPTP head-of-queue
// read port and the two event pulses. slave = buffer side, master = environment.
interface rx_buffer_if;
  logic        recv_vaild;
  logic        recv_ready;
  logic [79:0] recv_data;
  logic        recv_ts_vaild;
  logic [79:0] recv_ts_data;
  logic        gptp_rd_vaild;
  logic        gptp_rd_ready;
  logic [79:0] gptp_rd_data;
  logic [79:0] gptp_rd_ts;
  logic [7:0]  gptp_rd_seq;
  logic [7:0]  gptp_rd_count;
  logic        ts_drop;
  logic        overflow;

  modport slave (
    input  recv_vaild, recv_data, recv_ts_vaild, recv_ts_data, gptp_rd_ready,
    output recv_ready, gptp_rd_vaild, gptp_rd_data, gptp_rd_ts, gptp_rd_seq,
    output gptp_rd_count, ts_drop, overflow
  );

  modport master (
    output recv_vaild, recv_data, recv_ts_vaild, recv_ts_data, gptp_rd_ready,
    input  recv_ready, gptp_rd_vaild, gptp_rd_data, gptp_rd_ts, gptp_rd_seq,
    input  gptp_rd_count, ts_drop, overflow
  );
endinterface

// File: rtl/rx_buffer.sv
// Receive event buffer: pairs each header with its ingress timestamp and queues
// {header, ts, seq} for gPTP. Define RX_BUFFER_OVERWRITE_EN to overwrite oldest when full.
module rx_buffer #(
  parameter int DEPTH      = 16,
  parameter int TS_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  rx_buffer_if.slave   bus
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [7:0]     DEPTH_C = 8'(DEPTH);
  localparam logic [7:0]     TO_LAST = 8'(TS_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_TS = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [79:0]   r_stage;
  logic [7:0]    r_to_cnt;
  logic [7:0]    r_seq;
  logic [7:0]    r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic          r_ts_drop;
  logic          r_overflow;

  logic [79:0]   r_mem_hdr [DEPTH];
  logic [79:0]   r_mem_ts  [DEPTH];
  logic [7:0]    r_mem_seq [DEPTH];

  logic          w_full;
  logic          w_pop;
  logic          w_recv_ready;
  logic          w_accept;
  logic          w_commit;
  logic          w_timeout;
  logic          w_rd_adv;
  logic          w_ovf;

  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = (r_count != 8'd0) && bus.gptp_rd_ready;

`ifdef RX_BUFFER_OVERWRITE_EN
  // At full the write pointer sits on the head, so every commit retires the head.
  assign w_rd_adv = w_pop || (w_commit && w_full);
  assign w_ovf    = w_commit && w_full && !w_pop;
`else
  assign w_rd_adv = w_pop;
  assign w_ovf    = 1'b0;
`endif

  // Ingress FSM next-state and handshake decode
  always_comb begin
    w_state_nxt  = r_state;
    w_recv_ready = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef RX_BUFFER_OVERWRITE_EN
        w_recv_ready = 1'b1;
`else
        w_recv_ready = !w_full;
`endif
        w_accept = bus.recv_vaild && w_recv_ready;
        if (w_accept) begin
          w_state_nxt = WAIT_TS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_TS: begin
        if (bus.recv_ts_vaild) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_TS;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Staging register and timestamp wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage  <= 80'd0;
      r_to_cnt <= 8'd0;
    end else if (w_accept) begin
      r_stage  <= bus.recv_data;
      r_to_cnt <= 8'd0;
    end else if (r_state == WAIT_TS) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  // Pointers, occupancy, sequence number and event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= 8'd0;
      r_seq      <= 8'd0;
      r_ts_drop  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ts_drop  <= w_timeout;
      r_overflow <= w_ovf;
      if (w_commit) begin
        r_wptr <= r_wptr + PTR_ONE;
        r_seq  <= r_seq + 8'd1;
      end
      if (w_rd_adv) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_commit && !w_pop && !w_full) begin
        r_count <= r_count + 8'd1;
      end else if (!w_commit && w_pop) begin
        r_count <= r_count - 8'd1;
      end else begin
        r_count <= r_count;
      end
    end
  end

  // Entry storage; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem_hdr[r_wptr] <= r_stage;
      r_mem_ts[r_wptr]  <= bus.recv_ts_data;
      r_mem_seq[r_wptr] <= r_seq;
    end
  end

  assign bus.recv_ready    = w_recv_ready;
  assign bus.gptp_rd_vaild = (r_count != 8'd0);
  assign bus.gptp_rd_data  = r_mem_hdr[r_rptr];
  assign bus.gptp_rd_ts    = r_mem_ts[r_rptr];
  assign bus.gptp_rd_seq   = r_mem_seq[r_rptr];
  assign bus.gptp_rd_count = r_count;
  assign bus.ts_drop       = r_ts_drop;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer: stimulus pushes expected entries into a scoreboard,
// a negedge monitor pops and compares on every gPTP pop handshake.
module tb_rx_buffer;

  logic clk;
  logic reset;
  rx_buffer_if bus ();

  rx_buffer #(.DEPTH(16), .TS_TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [79:0] hdr;
    logic [79:0] ts;
    logic [7:0]  seq;
  } exp_t;

  exp_t       sb_q [$];
  int         checks   = 0;
  int         failures = 0;
  int         drop_cnt = 0;
  int         ovf_cnt  = 0;
  logic [7:0] exp_seq  = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor and event pulse counters
  always @(negedge clk) begin
    exp_t e;
    if (bus.gptp_rd_vaild === 1'b1 && bus.gptp_rd_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=seq %0d required=no entry", bus.gptp_rd_seq);
      end else begin
        e = sb_q.pop_front();
        chk("pop_hdr", bus.gptp_rd_data, e.hdr);
        chk("pop_ts",  bus.gptp_rd_ts,   e.ts);
        chk("pop_seq", 80'(bus.gptp_rd_seq), 80'(e.seq));
      end
    end
    if (bus.ts_drop === 1'b1)  drop_cnt++;
    if (bus.overflow === 1'b1) ovf_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.recv_vaild    = 1'b0;
    bus.recv_data     = 80'd0;
    bus.recv_ts_vaild = 1'b0;
    bus.recv_ts_data  = 80'd0;
    bus.gptp_rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    exp_seq  = 8'd0;
    drop_cnt = 0;
    ovf_cnt  = 0;
  endtask

  task automatic send_hdr(input logic [79:0] h);
    int n;
    n = 0;
    while (bus.recv_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL recv_ready_wait actual=%b required=1", bus.recv_ready);
    end
    bus.recv_vaild = 1'b1;
    bus.recv_data  = h;
    tick();
    bus.recv_vaild = 1'b0;
  endtask

  task automatic commit(input logic [79:0] h, input logic [79:0] t, input int gap, input bit pop_too);
    send_hdr(h);
    repeat (gap) tick();
    bus.recv_ts_vaild = 1'b1;
    bus.recv_ts_data  = t;
    bus.gptp_rd_ready = pop_too;
    sb_q.push_back('{hdr: h, ts: t, seq: exp_seq});
    exp_seq = exp_seq + 8'd1;
    tick();
    bus.recv_ts_vaild = 1'b0;
    bus.gptp_rd_ready = 1'b0;
  endtask

  task automatic pop_one();
    bus.gptp_rd_ready = 1'b1;
    tick();
    bus.gptp_rd_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.gptp_rd_ready = 1'b1;
    while (bus.gptp_rd_vaild === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    bus.gptp_rd_ready = 1'b0;
    chk("drain_count", 80'(bus.gptp_rd_count), 80'd0);
  endtask

  function automatic logic [79:0] mk_hdr(input int i);
    return {64'hA5A5_0000_0000_0000, 16'(i)};
  endfunction

  function automatic logic [79:0] mk_ts(input int i);
    return {48'(i + 100), 32'(i * 3)};
  endfunction

  initial begin
    // Reset state
    do_reset();
    chk("rst_recv_ready", 80'(bus.recv_ready), 80'd1);
    chk("rst_rd_vaild",   80'(bus.gptp_rd_vaild), 80'd0);
    chk("rst_count",      80'(bus.gptp_rd_count), 80'd0);
    chk("rst_ts_drop",    80'(bus.ts_drop), 80'd0);
    chk("rst_overflow",   80'(bus.overflow), 80'd0);

    // Basic commit, timestamp 3 cycles after header
    commit(80'h123456789abc00000002, 80'h000000000064_0000000a, 2, 1'b0);
    chk("basic_vaild", 80'(bus.gptp_rd_vaild), 80'd1);
    chk("basic_count", 80'(bus.gptp_rd_count), 80'd1);
    chk("basic_data",  bus.gptp_rd_data, 80'h123456789abc00000002);
    chk("basic_ts",    bus.gptp_rd_ts,   80'h000000000064_0000000a);
    chk("basic_seq",   80'(bus.gptp_rd_seq), 80'd0);
    pop_one();
    chk("basic_pop_count", 80'(bus.gptp_rd_count), 80'd0);
    chk("basic_pop_vaild", 80'(bus.gptp_rd_vaild), 80'd0);

    // Timestamp strobe while idle is ignored
    bus.recv_ts_vaild = 1'b1;
    bus.recv_ts_data  = 80'hdead;
    tick();
    bus.recv_ts_vaild = 1'b0;
    tick();
    chk("idle_ts_count", 80'(bus.gptp_rd_count), 80'd0);

    // Timestamp timeout
    do_reset();
    send_hdr(80'h0000_1111_2222_3333_4444);
    repeat (63) tick();
    chk("to_early_drop",  80'(bus.ts_drop), 80'd0);
    chk("to_early_ready", 80'(bus.recv_ready), 80'd0);
    tick();
    chk("to_drop",  80'(bus.ts_drop), 80'd1);
    chk("to_ready", 80'(bus.recv_ready), 80'd1);
    chk("to_count", 80'(bus.gptp_rd_count), 80'd0);
    tick();
    chk("to_drop_end", 80'(bus.ts_drop), 80'd0);
    chk("to_drop_cnt", 80'(drop_cnt), 80'd1);
    commit(mk_hdr(1), mk_ts(1), 0, 1'b0);
    chk("to_next_seq", 80'(bus.gptp_rd_seq), 80'd0);
    drain();

    // Reset while waiting for the timestamp
    do_reset();
    send_hdr(mk_hdr(2));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.recv_ts_vaild = 1'b1;
    bus.recv_ts_data  = mk_ts(2);
    tick();
    bus.recv_ts_vaild = 1'b0;
    tick();
    chk("rstw_count", 80'(bus.gptp_rd_count), 80'd0);
    chk("rstw_vaild", 80'(bus.gptp_rd_vaild), 80'd0);
    repeat (70) tick();
    chk("rstw_no_drop", 80'(drop_cnt), 80'd0);
    commit(mk_hdr(3), mk_ts(3), 1, 1'b0);
    chk("rstw_seq", 80'(bus.gptp_rd_seq), 80'd0);
    drain();

    // Simultaneous commit and pop at count 1
    do_reset();
    commit(mk_hdr(4), mk_ts(4), 0, 1'b0);
    commit(mk_hdr(5), mk_ts(5), 1, 1'b1);
    chk("sim_count", 80'(bus.gptp_rd_count), 80'd1);
    chk("sim_seq",   80'(bus.gptp_rd_seq), 80'd1);
    chk("sim_data",  bus.gptp_rd_data, mk_hdr(5));
    drain();

`ifdef RX_BUFFER_OVERWRITE_EN
    // Overwrite oldest when full
    do_reset();
    for (int i = 0; i < 17; i++) commit(mk_hdr(10 + i), mk_ts(10 + i), 0, 1'b0);
    tick();
    chk("ovf_pulses", 80'(ovf_cnt), 80'd1);
    chk("ovf_count",  80'(bus.gptp_rd_count), 80'd16);
    chk("ovf_seq",    80'(bus.gptp_rd_seq), 80'd1);
    chk("ovf_data",   bus.gptp_rd_data, mk_hdr(11));
    void'(sb_q.pop_front());
    commit(mk_hdr(40), mk_ts(40), 0, 1'b1);
    tick();
    chk("ovf_pop_pulses", 80'(ovf_cnt), 80'd1);
    chk("ovf_pop_count",  80'(bus.gptp_rd_count), 80'd16);
    chk("ovf_pop_seq",    80'(bus.gptp_rd_seq), 80'd2);
    drain();
`else
    // Full buffer back-pressure
    do_reset();
    for (int i = 0; i < 16; i++) commit(mk_hdr(10 + i), mk_ts(10 + i), 0, 1'b0);
    tick();
    chk("full_count", 80'(bus.gptp_rd_count), 80'd16);
    chk("full_ready", 80'(bus.recv_ready), 80'd0);
    chk("full_ovf",   80'(ovf_cnt), 80'd0);
    pop_one();
    chk("full_pop_ready", 80'(bus.recv_ready), 80'd1);
    chk("full_pop_seq",   80'(bus.gptp_rd_seq), 80'd1);
    chk("full_pop_count", 80'(bus.gptp_rd_count), 80'd15);
    commit(mk_hdr(30), mk_ts(30), 5, 1'b0);
    chk("last_slot_count", 80'(bus.gptp_rd_count), 80'd16);
    drain();
`endif

    tick();
    chk("sb_empty", 80'(sb_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
